trivium_keystream_gen: RTL and testbench

Bit-sliced Trivium keystream generator. It produces the 8-bit keystream bytes that the UART encryption datapath XORs with received characters. The block accepts an 80-bit key and an 80-bit IV and runs the Trivium warm-up. After warm-up it presents one keystream byte at a time on a valid/read handshake. It sits directly upstream of the character encryption and FIFO write logic and drives its keystream_byte and keystream_valid inputs.

---
 rtl/trivium_pkg.sv | 46 ++++
 rtl/trivium_round.sv | 28 ++
 rtl/trivium_keystream_gen.sv | 132 +++++++++++++
 tb/tb_trivium_keystream_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/trivium_pkg.sv
// Shared constants, FSM encoding and load-vector helper for the Trivium keystream generator.
// Tap constants use the 1-based s1..s288 numbering; bit s_i lives at vector index i-1.
package trivium_pkg;

    localparam int KEY_W   = 80;
    localparam int IV_W    = 80;
    localparam int STATE_W = 288;

    localparam int REG1_END = 93;
    localparam int REG2_END = 177;
    localparam int REG3_END = 288;

    localparam int S1_OUT   = 66;
    localparam int S1_FB    = 69;
    localparam int S1_AND_A = 91;
    localparam int S1_AND_B = 92;
    localparam int S1_LAST  = 93;
    localparam int S2_OUT   = 162;
    localparam int S2_FB    = 171;
    localparam int S2_AND_A = 175;
    localparam int S2_AND_B = 176;
    localparam int S2_LAST  = 177;
    localparam int S3_OUT   = 243;
    localparam int S3_FB    = 264;
    localparam int S3_AND_A = 286;
    localparam int S3_AND_B = 287;
    localparam int S3_LAST  = 288;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2
    } fsm_state_e;

    // Key into s1..s80, IV into s94..s173, ones into s286..s288, zeros elsewhere.
    function automatic logic [STATE_W-1:0] load_state(input logic [KEY_W-1:0] key,
                                                      input logic [IV_W-1:0]  iv);
        logic [STATE_W-1:0] s;
        s = '0;
        s[KEY_W-1:0] = key;
        s[REG1_END+IV_W-1:REG1_END] = iv;
        s[STATE_W-1:STATE_W-3] = 3'b111;
        return s;
    endfunction

endpackage

// File: rtl/trivium_round.sv
// One combinational Trivium round: produces the output bit z and the shifted state.
module trivium_round
    import trivium_pkg::*;
(
    input  logic [STATE_W-1:0] state,
    output logic [STATE_W-1:0] next_state,
    output logic               z
);

    logic t1;
    logic t2;
    logic t3;

    always_comb begin
        t1 = state[S1_OUT-1] ^ state[S1_LAST-1];
        t2 = state[S2_OUT-1] ^ state[S2_LAST-1];
        t3 = state[S3_OUT-1] ^ state[S3_LAST-1];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (state[S1_AND_A-1] & state[S1_AND_B-1]) ^ state[S2_FB-1];
        t2 = t2 ^ (state[S2_AND_A-1] & state[S2_AND_B-1]) ^ state[S3_FB-1];
        t3 = t3 ^ (state[S3_AND_A-1] & state[S3_AND_B-1]) ^ state[S1_FB-1];
        // Each register shifts toward higher indices; the last bit of each falls off.
        next_state = {state[REG3_END-2:REG2_END], t2,
                      state[REG2_END-2:REG1_END], t1,
                      state[REG1_END-2:0],        t3};
    end

endmodule

// File: rtl/trivium_keystream_gen.sv
// Trivium keystream generator: load key/IV, discard warm-up rounds, then serve bytes on a
// valid/read handshake. A byte is consumed on an edge where keystream_valid && keystream_read.
module trivium_keystream_gen
    import trivium_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 8,
    parameter int WARMUP_ROUNDS  = 1152
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [KEY_W-1:0] cfg_key,
    input  logic [IV_W-1:0]  cfg_iv,
    input  logic             keystream_read,
    output logic [7:0]       keystream_byte,
    output logic             keystream_valid,
    output logic             busy
);

    localparam int WARM_CYCLES = WARMUP_ROUNDS / BITS_PER_CYCLE;
    localparam int CNT_W       = $clog2(WARM_CYCLES + 1);
    localparam int SLOTS       = 8 / BITS_PER_CYCLE;
    localparam int SLOT_W      = $clog2(SLOTS + 1);

    fsm_state_e         state_q;
    fsm_state_e         state_d;
    logic [CNT_W-1:0]   warm_cnt;
    logic [CNT_W-1:0]   warm_cnt_d;
    logic [STATE_W-1:0] cipher;
    logic [STATE_W-1:0] cipher_d;
    logic [7:0]         acc;
    logic [7:0]         acc_d;
    logic [SLOT_W-1:0]  slot_cnt;
    logic [SLOT_W-1:0]  slot_cnt_d;
    logic [7:0]         ks_byte;
    logic [7:0]         ks_byte_d;
    logic               ks_valid;
    logic               ks_valid_d;
    logic               advance;
    logic [7:0]         acc_next;

    logic [STATE_W-1:0]        chain [0:BITS_PER_CYCLE];
    logic [BITS_PER_CYCLE-1:0] z_bits;

    assign chain[0] = cipher;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_round
        trivium_round u_round (
            .state      (chain[g]),
            .next_state (chain[g+1]),
            .z          (z_bits[g])
        );
    end

    // New z bits enter at the top so the earliest bit ends up in bit 0 once the byte fills.
    assign acc_next = 8'({z_bits, acc} >> BITS_PER_CYCLE);
    assign advance  = !ks_valid || keystream_read;

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt;
        cipher_d   = cipher;
        acc_d      = acc;
        slot_cnt_d = slot_cnt;
        ks_byte_d  = ks_byte;
        ks_valid_d = ks_valid;

        if (cfg_load) begin
            state_d    = WARMUP;
            warm_cnt_d = '0;
            cipher_d   = load_state(cfg_key, cfg_iv);
            acc_d      = '0;
            slot_cnt_d = '0;
            ks_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: ;
                WARMUP: begin
                    cipher_d = chain[BITS_PER_CYCLE];
                    if (warm_cnt == CNT_W'(WARM_CYCLES - 1)) begin
                        state_d    = RUN;
                        warm_cnt_d = '0;
                    end else begin
                        warm_cnt_d = warm_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (advance) begin
                        cipher_d = chain[BITS_PER_CYCLE];
                        acc_d    = acc_next;
                        if (slot_cnt == SLOT_W'(SLOTS - 1)) begin
                            ks_byte_d  = acc_next;
                            ks_valid_d = 1'b1;
                            slot_cnt_d = '0;
                        end else begin
                            slot_cnt_d = slot_cnt + 1'b1;
                            if (keystream_read) begin
                                ks_valid_d = 1'b0;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            warm_cnt <= '0;
            cipher   <= '0;
            acc      <= '0;
            slot_cnt <= '0;
            ks_byte  <= '0;
            ks_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            warm_cnt <= warm_cnt_d;
            cipher   <= cipher_d;
            acc      <= acc_d;
            slot_cnt <= slot_cnt_d;
            ks_byte  <= ks_byte_d;
            ks_valid <= ks_valid_d;
        end
    end

    assign keystream_byte  = ks_byte;
    assign keystream_valid = ks_valid;
    assign busy            = (state_q == WARMUP);

endmodule

// File: tb/tb_trivium_keystream_gen.sv
// Bench for trivium_keystream_gen: table of key/IV vectors checked against a bit-serial
// Trivium model, plus hand-written reset, stall, reload and mid-warm-up reset sequences.
module tb_trivium_keystream_gen;

    localparam int WARM_CYCLES = 144;
    localparam int FIRST_LAT   = 145;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_load = 1'b0;
    logic [79:0] cfg_key = '0;
    logic [79:0] cfg_iv = '0;
    logic        keystream_read = 1'b0;
    logic [7:0]  keystream_byte;
    logic        keystream_valid;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] exp_q[$];
    bit         ms [1:288];

    typedef struct {
        logic [79:0] key;
        logic [79:0] iv;
        int          nbytes;
        int          stall_at;
        int          exp_lat;
        int          exp_busy;
    } vec_t;

    vec_t vecs [0:5];

    trivium_keystream_gen dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_load        (cfg_load),
        .cfg_key         (cfg_key),
        .cfg_iv          (cfg_iv),
        .keystream_read  (keystream_read),
        .keystream_byte  (keystream_byte),
        .keystream_valid (keystream_valid),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model: the round rules applied literally on a 1-based bit array.
    task automatic model_load(input logic [79:0] key, input logic [79:0] iv);
        for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            ms[i]      = key[i-1];
            ms[93 + i] = iv[i-1];
        end
        ms[286] = 1'b1;
        ms[287] = 1'b1;
        ms[288] = 1'b1;
    endtask

    task automatic model_round(output bit z);
        bit t1, t2, t3;
        bit ns [1:288];
        t1 = ms[66] ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        ns[1] = t3;
        for (int i = 2; i <= 93; i++) ns[i] = ms[i-1];
        ns[94] = t1;
        for (int i = 95; i <= 177; i++) ns[i] = ms[i-1];
        ns[178] = t2;
        for (int i = 179; i <= 288; i++) ns[i] = ms[i-1];
        ms = ns;
    endtask

    task automatic model_gen(input logic [79:0] key, input logic [79:0] iv, input int n);
        bit z;
        logic [7:0] b;
        exp_q.delete();
        model_load(key, iv);
        for (int r = 0; r < 4 * 288; r++) model_round(z);
        for (int k = 0; k < n; k++) begin
            b = '0;
            for (int j = 0; j < 8; j++) begin
                model_round(z);
                b[j] = z;
            end
            exp_q.push_back(b);
        end
    endtask

    // Pulses cfg_load (optionally with a simultaneous read) and waits, bounded, for valid.
    task automatic load_and_wait(input logic [79:0] key, input logic [79:0] iv, input logic rd,
                                 output int lat, output int busy_n);
        cfg_key = key;
        cfg_iv = iv;
        cfg_load = 1'b1;
        keystream_read = rd;
        step();
        cfg_load = 1'b0;
        keystream_read = 1'b0;
        check("valid_cleared_by_load", 32'(keystream_valid), 32'd0);
        busy_n = busy ? 1 : 0;
        lat = 0;
        while (!keystream_valid && lat < 400) begin
            step();
            lat++;
            if (busy) busy_n++;
        end
    endtask

    task automatic stream_check(input int n, input int stall_at);
        logic [7:0] e;
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            check($sformatf("byte[%0d]", i), 32'(keystream_byte), 32'(e));
            check($sformatf("valid[%0d]", i), 32'(keystream_valid), 32'd1);
            if (i == stall_at) begin
                keystream_read = 1'b0;
                for (int s = 0; s < 20; s++) begin
                    step();
                    check($sformatf("stall_byte[%0d]", s), 32'(keystream_byte), 32'(e));
                    check($sformatf("stall_valid[%0d]", s), 32'(keystream_valid), 32'd1);
                end
            end
            keystream_read = 1'b1;
            step();
        end
        keystream_read = 1'b0;
    endtask

    initial begin
        int lat;
        int busy_n;
        int seen;

        vecs[0] = '{80'h0, 80'h0, 64, -1, FIRST_LAT, WARM_CYCLES};
        vecs[1] = '{80'h1, 80'h0, 64, -1, FIRST_LAT, WARM_CYCLES};
        vecs[2] = '{80'hFFFF_FFFF_FFFF_FFFF_FFFF, 80'h0123_4567_89AB_CDEF_0123, 64, -1,
                    FIRST_LAT, WARM_CYCLES};
        vecs[3] = '{80'h0, 80'h0, 24, 3, FIRST_LAT, WARM_CYCLES};
        for (int v = 4; v < 6; v++) begin
            vecs[v] = '{80'({$urandom(), $urandom(), $urandom()}),
                        80'({$urandom(), $urandom(), $urandom()}),
                        16 + int'($urandom_range(0, 16)), int'($urandom_range(0, 10)),
                        FIRST_LAT, WARM_CYCLES};
        end

        // Reset held three cycles with a load pulse inside it.
        rst = 1'b1;
        step();
        check("rst_valid", 32'(keystream_valid), 32'd0);
        check("rst_byte", 32'(keystream_byte), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        cfg_key = 80'h1234;
        cfg_load = 1'b1;
        step();
        check("rst_over_load_busy", 32'(busy), 32'd0);
        cfg_load = 1'b0;
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (busy || keystream_valid) seen++;
        end
        check("idle_after_reset", 32'(seen), 32'd0);
        check("idle_byte", 32'(keystream_byte), 32'd0);

        // Table: latency, busy width and streamed bytes against the model.
        for (int v = 0; v < 6; v++) begin
            model_gen(vecs[v].key, vecs[v].iv, vecs[v].nbytes);
            load_and_wait(vecs[v].key, vecs[v].iv, 1'b0, lat, busy_n);
            check($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            check($sformatf("vec%0d_busy_cycles", v), 32'(busy_n), 32'(vecs[v].exp_busy));
            check($sformatf("vec%0d_busy_low_in_run", v), 32'(busy), 32'd0);
            stream_check(vecs[v].nbytes, vecs[v].stall_at);
        end

        // Reload mid-run with a read on the same edge.
        model_gen(80'hA5A5_0000_1111_2222_3333, 80'h0F0F_F0F0_1234_5678_9ABC, 10);
        load_and_wait(80'hA5A5_0000_1111_2222_3333, 80'h0F0F_F0F0_1234_5678_9ABC, 1'b0,
                      lat, busy_n);
        check("reload_first_latency", 32'(lat), 32'(FIRST_LAT));
        stream_check(10, -1);
        model_gen(80'h5555_AAAA_0000_FFFF_1357, 80'h2468_ACE0_1357_9BDF_0000, 16);
        load_and_wait(80'h5555_AAAA_0000_FFFF_1357, 80'h2468_ACE0_1357_9BDF_0000, 1'b1,
                      lat, busy_n);
        check("reload_latency", 32'(lat), 32'(FIRST_LAT));
        check("reload_busy_cycles", 32'(busy_n), 32'(WARM_CYCLES));
        stream_check(16, -1);

        // Reset during warm-up cycle 70.
        cfg_key = 80'h0;
        cfg_iv = 80'h0;
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
        for (int i = 0; i < 69; i++) step();
        check("warmup_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midwarm_rst_busy", 32'(busy), 32'd0);
        check("midwarm_rst_valid", 32'(keystream_valid), 32'd0);
        check("midwarm_rst_byte", 32'(keystream_byte), 32'd0);
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (busy || keystream_valid) seen++;
        end
        check("midwarm_stays_idle", 32'(seen), 32'd0);
        model_gen(80'h0, 80'h0, 4);
        load_and_wait(80'h0, 80'h0, 1'b0, lat, busy_n);
        check("after_rst_latency", 32'(lat), 32'(FIRST_LAT));
        stream_check(4, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
